// File: rtl/pipelined_adder_if.sv
// Valid/ready operand and result channel for pipelined_adder.
// The master drives operands and out_ready; the slave is the adder.
interface pipelined_adder_if #(
  parameter int WIDTH = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, s, cout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, s, cout, ovf, zero
  );
endinterface

// File: rtl/pipelined_adder.sv
// Segmented ripple-carry adder/subtractor: one SEG_WIDTH slice per pipeline stage.
// All stages share one advance enable, so bubbles hold in place during a stall.
module pipelined_adder #(
  parameter int WIDTH     = 32,
  parameter int SEG_WIDTH = 8
) (
  input logic              clk,
  input logic              reset,
  pipelined_adder_if.slave bus
);
  localparam int STAGES = WIDTH / SEG_WIDTH;

  typedef struct packed {
    logic             vld;
    logic             c;
    logic             ovf;
    logic             zero;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] s;
  } stage_t;

  stage_t r_pipe [STAGES];
  stage_t w_nxt  [STAGES];
  stage_t w_head;
  logic   w_adv;

  // Adds slice k of a and b plus the carry from slice k-1; lower result and upper operands pass through.
  function automatic stage_t slice_add(input stage_t src, input int k);
    stage_t             res;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [WIDTH-1:0]   seg_mask;
    logic [WIDTH-1:0]   seg_val;
    logic [SEG_WIDTH:0] sum;
    res      = src;
    a_sh     = src.a >> (k * SEG_WIDTH);
    b_sh     = src.b >> (k * SEG_WIDTH);
    sum      = {1'b0, a_sh[SEG_WIDTH-1:0]} + {1'b0, b_sh[SEG_WIDTH-1:0]}
             + {{SEG_WIDTH{1'b0}}, src.c};
    seg_mask = {WIDTH{1'b0}};
    seg_mask[SEG_WIDTH-1:0] = {SEG_WIDTH{1'b1}};
    seg_val  = {WIDTH{1'b0}};
    seg_val[SEG_WIDTH-1:0]  = sum[SEG_WIDTH-1:0];
    res.s    = (src.s & ~(seg_mask << (k * SEG_WIDTH))) | (seg_val << (k * SEG_WIDTH));
    res.c    = sum[SEG_WIDTH];
    // Only meaningful in the top slice: carry into MSB recovered from the MSB sum bit.
    res.ovf  = src.a[WIDTH-1] ^ src.b[WIDTH-1] ^ sum[SEG_WIDTH-1] ^ sum[SEG_WIDTH];
    res.zero = ~|res.s;
    return res;
  endfunction

  assign w_adv        = ~r_pipe[STAGES-1].vld | bus.out_ready;
  assign bus.in_ready = w_adv;

  // Operand capture; subtraction is folded into a + ~b + 1 here.
  always_comb begin
    w_head     = '0;
    w_head.vld = bus.in_valid & w_adv;
    w_head.a   = bus.a;
    if (bus.sub) begin
      w_head.b = ~bus.b;
      w_head.c = 1'b1;
    end else begin
      w_head.b = bus.b;
      w_head.c = bus.cin;
    end
  end

  // Each slice consumes the previous stage register; slice 0 consumes the captured operands.
  always_comb begin
    w_nxt[0] = slice_add(w_head, 0);
    for (int k = 1; k < STAGES; k++) begin
      w_nxt[k] = slice_add(r_pipe[k-1], k);
    end
  end

  // Stage registers advance together or hold together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) begin
        r_pipe[k] <= '0;
      end
    end else if (w_adv) begin
      for (int k = 0; k < STAGES; k++) begin
        r_pipe[k] <= w_nxt[k];
      end
    end
  end

  assign bus.out_valid = r_pipe[STAGES-1].vld;
  assign bus.s         = r_pipe[STAGES-1].s;
  assign bus.cout      = r_pipe[STAGES-1].c;
  assign bus.ovf       = r_pipe[STAGES-1].ovf;
  assign bus.zero      = r_pipe[STAGES-1].zero;
endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder: directed table on 32/8, stream/stall/reset
// sequences, and randomized runs on 32/8, 16/4 and 8/8 against an arithmetic model.
module tb_pipelined_adder;
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pipelined_adder_if #(.WIDTH(32)) bus32 ();
  pipelined_adder_if #(.WIDTH(16)) bus16 ();
  pipelined_adder_if #(.WIDTH(8))  bus8 ();

  pipelined_adder #(.WIDTH(32), .SEG_WIDTH(8)) u_dut32 (.clk(clk), .reset(reset), .bus(bus32));
  pipelined_adder #(.WIDTH(16), .SEG_WIDTH(4)) u_dut16 (.clk(clk), .reset(reset), .bus(bus16));
  pipelined_adder #(.WIDTH(8),  .SEG_WIDTH(8)) u_dut8  (.clk(clk), .reset(reset), .bus(bus8));

  typedef struct {
    logic [31:0] s;
    logic        cout;
    logic        ovf;
    logic        zero;
    int          cnt;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] s;
    logic        cout;
    logic        ovf;
    logic        zero;
  } vec_t;

  int   n_vec = 0;
  int   n_err = 0;
  vec_t tbl [9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drv(input int d, input logic iv, input logic [31:0] a, input logic [31:0] b,
                     input logic cin, input logic sub, input logic ordy);
    case (d)
      0: begin
        bus32.in_valid = iv; bus32.a = a; bus32.b = b;
        bus32.cin = cin; bus32.sub = sub; bus32.out_ready = ordy;
      end
      1: begin
        bus16.in_valid = iv; bus16.a = a[15:0]; bus16.b = b[15:0];
        bus16.cin = cin; bus16.sub = sub; bus16.out_ready = ordy;
      end
      default: begin
        bus8.in_valid = iv; bus8.a = a[7:0]; bus8.b = b[7:0];
        bus8.cin = cin; bus8.sub = sub; bus8.out_ready = ordy;
      end
    endcase
  endtask

  task automatic smp(input int d, output logic ir, output logic ov, output logic [31:0] s,
                     output logic co, output logic of, output logic z);
    case (d)
      0: begin
        ir = bus32.in_ready; ov = bus32.out_valid; s = bus32.s;
        co = bus32.cout; of = bus32.ovf; z = bus32.zero;
      end
      1: begin
        ir = bus16.in_ready; ov = bus16.out_valid; s = {16'h0, bus16.s};
        co = bus16.cout; of = bus16.ovf; z = bus16.zero;
      end
      default: begin
        ir = bus8.in_ready; ov = bus8.out_valid; s = {24'h0, bus8.s};
        co = bus8.cout; of = bus8.ovf; z = bus8.zero;
      end
    endcase
  endtask

  // Arithmetic reference: plain integer add/subtract with signed range check.
  function automatic exp_t ref_model(input int w, input logic [31:0] a, input logic [31:0] b,
                                     input logic cin, input logic sub);
    exp_t   r;
    longint m, ua, ub, sa, sb, full, sres;
    m  = longint'(1) << w;
    ua = longint'(a);
    ub = longint'(b);
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    if (sub) begin
      full   = ua - ub;
      sres   = sa - sb;
      r.cout = (ua >= ub);
    end else begin
      full   = ua + ub + longint'(cin);
      sres   = sa + sb + longint'(cin);
      r.cout = (full >= m);
    end
    r.s    = 32'(full & (m - 1));
    r.ovf  = (sres >= m / 2) || (sres < -(m / 2));
    r.zero = (r.s == 32'h0);
    r.cnt  = 0;
    return r;
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    logic ir, ov, co, of, z;
    logic [31:0] s;
    int lat = -1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c == 0) drv(0, 1'b1, v.a, v.b, v.cin, v.sub, 1'b1);
      else        drv(0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
      #4 smp(0, ir, ov, s, co, of, z);
      if (c == 0) chk({tag, "_in_ready"}, 64'(ir), 64'd1);
      if (ov) begin
        lat = c;
        break;
      end
    end
    chk({tag, "_latency"}, 64'(lat), 64'd4);
    chk({tag, "_s"},    64'(s),  64'(v.s));
    chk({tag, "_cout"}, 64'(co), 64'(v.cout));
    chk({tag, "_ovf"},  64'(of), 64'(v.ovf));
    chk({tag, "_zero"}, 64'(z),  64'(v.zero));
  endtask

  task automatic stream(input bit stall);
    logic ir, ov, co, of, z, ordy;
    logic [31:0] s, hs = 32'h0;
    bit hv = 1'b0;
    int idx = 0, nout = 0, first = -1, last = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      ordy = !(stall && c >= 5 && c <= 7);
      drv(0, idx < 8, 32'(idx + 1), 32'(idx + 1), 1'b0, 1'b0, ordy);
      #4 smp(0, ir, ov, s, co, of, z);
      if (!ordy) chk("stall_in_ready", 64'(ir), 64'd0);
      if (hv)    chk("stall_hold_s", 64'(s), 64'(hs));
      hv = ov && !ordy;
      hs = s;
      if (ov) begin
        if (nout < 8) chk("stream_s", 64'(s), 64'(2 * (nout + 1)));
        else          chk("stream_extra", 64'(ov), 64'd0);
        if (ordy) begin
          if (first < 0) first = c;
          last = c;
          nout++;
        end
      end
      if (idx < 8 && ir) idx++;
    end
    chk("stream_count", 64'(nout), 64'd8);
    if (!stall) begin
      chk("stream_first", 64'(first), 64'd4);
      chk("stream_last",  64'(last),  64'd11);
    end
  endtask

  task automatic rand_run(input int d, input int w, input int st, input int n);
    exp_t q[$];
    logic [31:0] mask, ra = 32'h0, rb = 32'h0, s, hs = 32'h0;
    logic iv = 1'b0, rc = 1'b0, rs = 1'b0, ordy, ir, ov, co, of, z;
    bit hold = 1'b0, pend = 1'b0, exp_ov, exp_adv;
    int sent = 0, got = 0;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    for (int c = 0; c < 8000 && got < n; c++) begin
      @(negedge clk);
      if (!pend) begin
        iv = (sent < n) && ($urandom_range(0, 3) != 0);
        ra = $urandom & mask;
        rb = $urandom & mask;
        if ($urandom_range(0, 7) == 0) ra = mask;
        if ($urandom_range(0, 7) == 0) rb = ra;
        rc = 1'($urandom);
        rs = 1'($urandom);
      end
      ordy = ($urandom_range(0, 2) != 0);
      drv(d, iv, ra, rb, rc, rs, ordy);
      #4 smp(d, ir, ov, s, co, of, z);
      exp_ov  = (q.size() > 0) && (q[0].cnt == st);
      exp_adv = !exp_ov || ordy;
      chk("rand_out_valid", 64'(ov), 64'(exp_ov));
      chk("rand_in_ready",  64'(ir), 64'(exp_adv));
      if (hold) chk("rand_hold_s", 64'(s), 64'(hs));
      if (exp_ov && ov) begin
        chk("rand_s",    64'(s),  64'(q[0].s));
        chk("rand_cout", 64'(co), 64'(q[0].cout));
        chk("rand_ovf",  64'(of), 64'(q[0].ovf));
        chk("rand_zero", 64'(z),  64'(q[0].zero));
      end
      hold = ov && !ordy;
      hs   = s;
      if (exp_ov && ordy) begin
        void'(q.pop_front());
        got++;
      end
      if (iv && exp_adv) begin
        q.push_back(ref_model(w, ra, rb, rc, rs));
        sent++;
        pend = 1'b0;
      end else begin
        pend = iv;
      end
      if (exp_adv) foreach (q[i]) q[i].cnt++;
    end
    chk("rand_count", 64'(got), 64'(n));
    @(negedge clk);
    drv(d, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    logic ir, ov, co, of, z;
    logic [31:0] s;

    tbl[0] = '{32'h0000_0005, 32'h0000_0003, 1'b1, 1'b0, 32'h0000_0009, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    tbl[2] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{32'h0000_0003, 32'h0000_0005, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1};
    tbl[6] = '{32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0007, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    tbl[8] = '{32'h00FF_00FF, 32'h0001_FF01, 1'b0, 1'b0, 32'h0101_0000, 1'b0, 1'b0, 1'b0};

    for (int d = 0; d < 3; d++) drv(d, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);

    #2;
    for (int d = 0; d < 3; d++) begin
      smp(d, ir, ov, s, co, of, z);
      chk("reset_out_valid", 64'(ov), 64'd0);
      chk("reset_s",         64'(s),  64'd0);
      chk("reset_flags",     64'({co, of, z}), 64'd0);
    end
    @(negedge clk);
    reset = 1'b0;
    #1 smp(0, ir, ov, s, co, of, z);
    chk("post_reset_in_ready", 64'(ir), 64'd1);

    for (int i = 0; i < 9; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    stream(1'b0);
    stream(1'b1);

    // Fill the pipeline with the output stalled, then reset mid-flight.
    @(negedge clk); drv(0, 1'b1, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0);
    @(negedge clk); drv(0, 1'b1, 32'h2, 32'h2, 1'b0, 1'b0, 1'b0);
    @(negedge clk); drv(0, 1'b1, 32'h3, 32'h3, 1'b0, 1'b0, 1'b0);
    @(negedge clk); drv(0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1 smp(0, ir, ov, s, co, of, z);
    chk("preflush_out_valid", 64'(ov), 64'd1);
    chk("preflush_cout",      64'(co), 64'd1);
    chk("preflush_zero",      64'(z),  64'd1);
    #1 reset = 1'b1;
    #1 smp(0, ir, ov, s, co, of, z);
    chk("flush_out_valid", 64'(ov), 64'd0);
    chk("flush_s",         64'(s),  64'd0);
    chk("flush_flags",     64'({co, of, z}), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1 smp(0, ir, ov, s, co, of, z);
    chk("flush_in_ready", 64'(ir), 64'd1);
    run_vec('{32'h1, 32'h1, 1'b0, 1'b0, 32'h2, 1'b0, 1'b0, 1'b0}, "after_reset");

    rand_run(1, 16, 4, 1000);
    rand_run(2, 8, 1, 1000);
    rand_run(0, 32, 4, 300);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
